// File: rtl/riscv_mem_dma.sv
// riscv_mem_dma: data-port initiator for block COPY, FILL and SUM over the
// RISC-V data memory window. dReadData has one cycle of read latency.
module riscv_mem_dma #(
    parameter logic [31:0] DATA_START_ADDRESS = 32'h00800000,
    parameter int          DATA_BRAMS         = 2,
    parameter int          LEN_W              = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [LEN_W-1:0] len_words,
    input  logic [31:0]      fill_value,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [31:0]      result,
    output logic [31:0]      dAddress,
    output logic             MemWrite,
    output logic [31:0]      dWriteData,
    input  logic [31:0]      dReadData
);

    localparam int          WIN_LSB  = 11 + DATA_BRAMS;
    localparam logic [31:0] WIN_TAG  = DATA_START_ADDRESS >> WIN_LSB;
    localparam logic [1:0]  OP_COPY  = 2'd0;
    localparam logic [1:0]  OP_FILL  = 2'd1;
    localparam logic [1:0]  OP_SUM   = 2'd2;
    localparam logic [1:0]  OP_RSVD  = 2'd3;

    typedef enum logic [2:0] {
        IDLE, CPY_RD, CPY_WR, FILL, SUM_RD, SUM_LAST, DONE
    } state_t;

    state_t           state;
    logic [31:0]      src_ptr;
    logic [31:0]      dst_ptr;
    logic [LEN_W-1:0] cnt;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      acc;
    logic             sum_vld;
    logic [31:0]      wdata_q;

    logic [LEN_W-1:0] len_m1;
    logic [31:0]      last_off;
    logic             use_src;
    logic             use_dst;
    logic             src_bad;
    logic             dst_bad;
    logic             cmd_err;

    // Command validation: opcode, alignment, and first/last word inside the window
    always_comb begin
        len_m1   = (len_words == '0) ? '0 : len_words - LEN_W'(1);
        last_off = 32'(len_m1) << 2;
        use_src  = (op == OP_COPY) || (op == OP_SUM);
        use_dst  = (op == OP_COPY) || (op == OP_FILL);
        src_bad  = (src_addr[1:0] != 2'b00)
                || ((src_addr >> WIN_LSB) != WIN_TAG)
                || (((src_addr + last_off) >> WIN_LSB) != WIN_TAG);
        dst_bad  = (dst_addr[1:0] != 2'b00)
                || ((dst_addr >> WIN_LSB) != WIN_TAG)
                || (((dst_addr + last_off) >> WIN_LSB) != WIN_TAG);
        cmd_err  = (op == OP_RSVD) || (use_src && src_bad) || (use_dst && dst_bad);
    end

    // Copy writes forward the word read in the previous cycle straight from the memory port
    assign dWriteData = (state == CPY_WR) ? dReadData : wdata_q;

    // Sequencer with registered memory-port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            result   <= '0;
            dAddress <= '0;
            MemWrite <= 1'b0;
            wdata_q  <= '0;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            cnt      <= '0;
            len_q    <= '0;
            acc      <= '0;
            sum_vld  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        error   <= 1'b0;
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        cnt     <= len_words;
                        len_q   <= len_words;
                        acc     <= '0;
                        sum_vld <= 1'b0;
                        if (cmd_err) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            error  <= 1'b1;
                            result <= '0;
                        end else if (len_words == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            busy <= 1'b1;
                            case (op)
                                OP_COPY: begin
                                    state    <= CPY_RD;
                                    dAddress <= src_addr;
                                end
                                OP_FILL: begin
                                    state    <= FILL;
                                    dAddress <= dst_addr;
                                    MemWrite <= 1'b1;
                                    wdata_q  <= fill_value;
                                end
                                default: begin
                                    state    <= SUM_RD;
                                    dAddress <= src_addr;
                                end
                            endcase
                        end
                    end
                end
                CPY_RD: begin
                    state    <= CPY_WR;
                    dAddress <= dst_ptr;
                    MemWrite <= 1'b1;
                end
                CPY_WR: begin
                    MemWrite <= 1'b0;
                    if (cnt == LEN_W'(1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        dAddress <= '0;
                        result   <= 32'(len_q);
                    end else begin
                        state    <= CPY_RD;
                        cnt      <= cnt - LEN_W'(1);
                        src_ptr  <= src_ptr + 32'd4;
                        dst_ptr  <= dst_ptr + 32'd4;
                        dAddress <= src_ptr + 32'd4;
                    end
                end
                FILL: begin
                    if (cnt == LEN_W'(1)) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        MemWrite <= 1'b0;
                        dAddress <= '0;
                        wdata_q  <= '0;
                        result   <= 32'(len_q);
                    end else begin
                        cnt      <= cnt - LEN_W'(1);
                        dAddress <= dAddress + 32'd4;
                    end
                end
                SUM_RD: begin
                    // The first issue cycle has no returning data yet
                    acc     <= acc + (sum_vld ? dReadData : 32'd0);
                    sum_vld <= 1'b1;
                    if (cnt == LEN_W'(1)) begin
                        state    <= SUM_LAST;
                        dAddress <= '0;
                    end else begin
                        cnt      <= cnt - LEN_W'(1);
                        dAddress <= dAddress + 32'd4;
                    end
                end
                SUM_LAST: begin
                    state  <= DONE;
                    busy   <= 1'b0;
                    done   <= 1'b1;
                    result <= acc + dReadData;
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    MemWrite <= 1'b0;
                    dAddress <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_dma.sv
// tb_riscv_mem_dma: directed table, random commands against a word-array
// reference model, and hand sequences for start-while-busy and mid-op reset.
module tb_riscv_mem_dma;

    localparam logic [31:0] BASE = 32'h00800000;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [11:0] len_words;
    logic [31:0] fill_value;
    logic        busy;
    logic        done;
    logic        error;
    logic [31:0] result;
    logic [31:0] dAddress;
    logic        MemWrite;
    logic [31:0] dWriteData;
    logic [31:0] dReadData;

    always #5 clk = ~clk;

    riscv_mem_dma #(
        .DATA_START_ADDRESS(32'h00800000),
        .DATA_BRAMS(2),
        .LEN_W(12)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .src_addr(src_addr), .dst_addr(dst_addr), .len_words(len_words),
        .fill_value(fill_value), .busy(busy), .done(done), .error(error),
        .result(result), .dAddress(dAddress), .MemWrite(MemWrite),
        .dWriteData(dWriteData), .dReadData(dReadData)
    );

    // Memory: 8 KB window, synchronous read, plus a backdoor write port
    logic [31:0] mem [0:2047];
    logic [31:0] mdl [0:2047];
    logic        bd_we = 1'b0;
    logic [10:0] bd_idx;
    logic [31:0] bd_data;
    int          stray = 0;

    function automatic bit win(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'h2000);
    endfunction

    always @(posedge clk) begin
        if (bd_we) mem[bd_idx] <= bd_data;
        else if (MemWrite) begin
            if (win(dAddress)) mem[dAddress[12:2]] <= dWriteData;
            else stray <= stray + 1;
        end
        dReadData <= win(dAddress) ? mem[dAddress[12:2]] : 32'h0;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic bd_write(input int i, input logic [31:0] v);
        bd_we   = 1'b1;
        bd_idx  = i[10:0];
        bd_data = v;
        mdl[i]  = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== mdl[i]) n++;
        return n;
    endfunction

    // Reference model: whole-command semantics on a word array
    task automatic ref_cmd(input logic [1:0] o, input logic [31:0] s, input logic [31:0] d,
                           input logic [11:0] l, input logic [31:0] f,
                           output logic err, output logic [31:0] res,
                           output int n, output int wr);
        int          lm1;
        int          si;
        int          di;
        logic [31:0] sl;
        logic [31:0] dl;
        bit          us;
        bit          ud;
        lm1 = (l == 0) ? 0 : int'(l) - 1;
        sl  = s + 32'(4 * lm1);
        dl  = d + 32'(4 * lm1);
        us  = (o == 2'd0) || (o == 2'd2);
        ud  = (o == 2'd0) || (o == 2'd1);
        err = (o == 2'd3)
           || (us && (s[1:0] != 0 || !win(s) || !win(sl)))
           || (ud && (d[1:0] != 0 || !win(d) || !win(dl)));
        res = 0; n = 0; wr = 0;
        if (err || l == 0) return;
        si = int'((s - BASE) >> 2);
        di = int'((d - BASE) >> 2);
        case (o)
            2'd0: begin
                for (int i = 0; i < int'(l); i++) mdl[di + i] = mdl[si + i];
                res = 32'(l); n = 2 * int'(l); wr = int'(l);
            end
            2'd1: begin
                for (int i = 0; i < int'(l); i++) mdl[di + i] = f;
                res = 32'(l); n = int'(l); wr = int'(l);
            end
            default: begin
                for (int i = 0; i < int'(l); i++) res = res + mdl[si + i];
                n = int'(l) + 1;
            end
        endcase
    endtask

    // Issue one command and compare timing, status, write count and memory
    task automatic run_check(input string nm, input logic [1:0] o, input logic [31:0] s,
                             input logic [31:0] d, input logic [11:0] l, input logic [31:0] f,
                             input logic exp_err, input logic [31:0] exp_res,
                             input int exp_n, input int exp_wr);
        int n_wait = 1;
        int n_busy = 0;
        int n_wr   = 0;
        @(negedge clk);
        start = 1'b1; op = o; src_addr = s; dst_addr = d; len_words = l; fill_value = f;
        @(negedge clk);
        start = 1'b0;
        while (!done && n_wait < 20000) begin
            if (busy) n_busy++;
            if (MemWrite) n_wr++;
            @(negedge clk);
            n_wait++;
        end
        chk({nm, ".done_cycle"}, n_wait, exp_n + 1);
        chk({nm, ".busy_cycles"}, n_busy, exp_n);
        chk({nm, ".writes"}, n_wr, exp_wr);
        chk({nm, ".busy_at_done"}, {31'b0, busy}, 0);
        @(negedge clk);
        chk({nm, ".done_pulse"}, {31'b0, done}, 0);
        chk({nm, ".result"}, result, exp_res);
        chk({nm, ".error"}, {31'b0, error}, {31'b0, exp_err});
        chk({nm, ".idle_port"}, {dAddress[30:0], MemWrite}, 0);
        chk({nm, ".mem"}, mem_diffs(), 0);
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] src;
        logic [31:0] dst;
        logic [11:0] len;
        logic [31:0] fill;
        bit          pre;
        logic [31:0] p0, p1, p2;
        logic        exp_err;
        logic [31:0] exp_res;
        int          exp_n;
        int          exp_wr;
    } vec_t;

    function automatic logic [31:0] rnd_addr();
        int r = int'($urandom_range(0, 19));
        if (r == 0) return 32'h00400000 + 32'(4 * $urandom_range(0, 100));
        if (r == 1) return BASE + 32'(4 * $urandom_range(0, 2047)) + 32'(2 - $urandom_range(0, 1));
        if (r < 4)  return BASE + 32'(4 * (2048 - $urandom_range(1, 30)));
        return BASE + 32'(4 * $urandom_range(0, 2047));
    endfunction

    vec_t tbl [12];

    initial begin
        logic        e;
        logic [31:0] r;
        int          n;
        int          wr;
        int          w;
        logic [1:0]  o;
        logic [31:0] s;
        logic [31:0] d;
        logic [11:0] l;
        logic [31:0] f;

        tbl[0]  = '{2'd1, 32'h0, 32'h00800100, 12'd4, 32'hDEADBEEF, 0, 0, 0, 0, 1'b0, 32'd4, 4, 4};
        tbl[1]  = '{2'd0, 32'h00800000, 32'h00800040, 12'd3, 32'h0, 1, 1, 2, 3, 1'b0, 32'd3, 6, 3};
        tbl[2]  = '{2'd2, 32'h00800000, 32'h0, 12'd3, 32'h0, 1, 32'hFFFFFFFF, 2, 32'h10, 1'b0, 32'h11, 4, 0};
        tbl[3]  = '{2'd3, 32'h00800000, 32'h00800040, 12'd2, 32'h0, 0, 0, 0, 0, 1'b1, 32'd0, 0, 0};
        tbl[4]  = '{2'd1, 32'h0, 32'h00800002, 12'd1, 32'h1, 0, 0, 0, 0, 1'b1, 32'd0, 0, 0};
        tbl[5]  = '{2'd1, 32'h0, 32'h00801FFC, 12'd2, 32'h1, 0, 0, 0, 0, 1'b1, 32'd0, 0, 0};
        tbl[6]  = '{2'd2, 32'h00400000, 32'h0, 12'd1, 32'h0, 0, 0, 0, 0, 1'b1, 32'd0, 0, 0};
        tbl[7]  = '{2'd1, 32'h0, 32'h00800200, 12'd1, 32'h5, 0, 0, 0, 0, 1'b0, 32'd1, 1, 1};
        tbl[8]  = '{2'd1, 32'h0, 32'h00800300, 12'd0, 32'h9, 0, 0, 0, 0, 1'b0, 32'd0, 0, 0};
        tbl[9]  = '{2'd0, 32'h00800800, 32'h00800804, 12'd3, 32'h0, 1, 7, 8, 9, 1'b0, 32'd3, 6, 3};
        tbl[10] = '{2'd1, 32'h0, 32'h00801FFC, 12'd1, 32'hCAFEF00D, 0, 0, 0, 0, 1'b0, 32'd1, 1, 1};
        tbl[11] = '{2'd2, 32'h00800100, 32'h0, 12'd4, 32'h0, 0, 0, 0, 0, 1'b0, 32'h7AB6FBBC, 5, 0};

        rst = 1'b1; start = 1'b0; op = 2'd0; src_addr = '0; dst_addr = '0;
        len_words = '0; fill_value = '0;
        repeat (3) @(negedge clk);
        chk("reset.status", {28'b0, busy, done, error, MemWrite}, 0);
        chk("reset.result", result, 0);
        chk("reset.daddr", dAddress, 0);
        chk("reset.wdata", dWriteData, 0);
        rst = 1'b0;

        for (int i = 0; i < 2048; i++) bd_write(i, $urandom);

        // Directed table
        for (int v = 0; v < 12; v++) begin
            if (tbl[v].pre) begin
                w = int'((tbl[v].src - BASE) >> 2);
                bd_write(w, tbl[v].p0);
                bd_write(w + 1, tbl[v].p1);
                bd_write(w + 2, tbl[v].p2);
            end
            ref_cmd(tbl[v].op, tbl[v].src, tbl[v].dst, tbl[v].len, tbl[v].fill, e, r, n, wr);
            run_check($sformatf("vec%0d", v), tbl[v].op, tbl[v].src, tbl[v].dst, tbl[v].len,
                      tbl[v].fill, tbl[v].exp_err, tbl[v].exp_res, tbl[v].exp_n, tbl[v].exp_wr);
        end

        // Start pulses during a COPY must not disturb it
        ref_cmd(2'd0, 32'h00800600, 32'h00800700, 12'd6, 32'h0, e, r, n, wr);
        @(negedge clk);
        start = 1'b1; op = 2'd0; src_addr = 32'h00800600; dst_addr = 32'h00800700; len_words = 12'd6;
        @(negedge clk);
        start = 1'b0;
        w = 1;
        repeat (2) begin @(negedge clk); w++; end
        start = 1'b1; op = 2'd1; dst_addr = 32'h00800710; len_words = 12'd3; fill_value = 32'h12345678;
        @(negedge clk);
        w++;
        start = 1'b0;
        while (!done && w < 200) begin @(negedge clk); w++; end
        chk("busy_start.done_cycle", w, 13);
        @(negedge clk);
        chk("busy_start.result", result, 6);
        chk("busy_start.error", {31'b0, error}, 0);
        chk("busy_start.mem", mem_diffs(), 0);

        // Synchronous reset after two of eight FILL writes
        for (int i = 0; i < 2; i++) mdl[256 + i] = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b1; op = 2'd1; dst_addr = 32'h00800400; len_words = 12'd8; fill_value = 32'hA5A5A5A5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid.status", {29'b0, busy, done, MemWrite}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid.after", {29'b0, busy, done, MemWrite}, 0);
        chk("rst_mid.mem", mem_diffs(), 0);
        ref_cmd(2'd1, 32'h0, 32'h00800400, 12'd8, 32'h0BADCAFE, e, r, n, wr);
        run_check("rst_refill", 2'd1, 32'h0, 32'h00800400, 12'd8, 32'h0BADCAFE, e, r, n, wr);

        // Random commands against the reference model
        for (int t = 0; t < 40; t++) begin
            w = int'($urandom_range(0, 9));
            o = (w == 9) ? 2'd3 : 2'(w % 3);
            s = rnd_addr();
            d = rnd_addr();
            l = ($urandom_range(0, 5) == 0) ? 12'd0 : 12'($urandom_range(1, 24));
            f = $urandom;
            ref_cmd(o, s, d, l, f, e, r, n, wr);
            run_check($sformatf("rnd%0d", t), o, s, d, l, f, e, r, n, wr);
        end

        chk("stray_writes", stray, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_mem_dma.md
Name: riscv_mem_dma

Overview:
- Data-port initiator for the RISC-V instruction/data memory block.
- Drives dAddress/MemWrite/dWriteData and consumes dReadData, which has 1-cycle synchronous read latency.
- Performs word-granular block COPY, FILL and SUM (checksum) over the data window.
- Used for memory init/clear, self-test and debug; it sits beside the processor data port and the system muxes it onto that port.

Parameters:
- DATA_START_ADDRESS, 32'h00800000, base of the data window.
- DATA_BRAMS, 2, window size = 2^(11+DATA_BRAMS) bytes.
- LEN_W, 12, width of the word-count operand.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- start  in  1  command strobe, sampled only in IDLE.
- op  in  2  0=COPY, 1=FILL, 2=SUM, 3=reserved.
- src_addr  in  32  source byte address (COPY, SUM).
- dst_addr  in  32  destination byte address (COPY, FILL).
- len_words  in  LEN_W  number of words.
- fill_value  in  32  FILL pattern.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  last command rejected.
- result  out  32  SUM: checksum; COPY/FILL: words written.
- dAddress  out  32  memory data address.
- MemWrite  out  1  memory write enable.
- dWriteData  out  32  memory write data.
- dReadData  in  32  memory read data; reflects the dAddress of the previous cycle.

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
- Reset values: state=IDLE; busy, done, error, MemWrite = 0; result, dAddress, dWriteData = 0.
- Reset mid-operation aborts immediately. No done pulse; no further writes.
- IDLE outputs: dAddress=0, MemWrite=0, dWriteData=0.
- start while busy or in DONE is ignored.
- On start in IDLE, latch all operands and validate combinationally.
  - Error conditions: op==3; a used address has [1:0]!=0; first or last word of a used range lies outside the window.
  - Window test: addr[31:11+DATA_BRAMS]==DATA_START_ADDRESS[31:11+DATA_BRAMS].
  - On error: go to DONE, set error=1, result=0, no memory access.
- len_words==0 with valid op: go to DONE, result=0, no access, error=0.
- error and result hold until the next accepted start, which clears error.
- States: IDLE, CPY_RD, CPY_WR, FILL, SUM_RD, SUM_LAST, DONE.
- COPY: alternates CPY_RD and CPY_WR.
  - CPY_RD: dAddress=src_ptr, MemWrite=0.
  - CPY_WR: dAddress=dst_ptr, MemWrite=1, dWriteData=dReadData.
  - Pointers += 4 after CPY_WR.
  - Busy for 2*len cycles, 1 word per 2 cycles.
  - Overlap is strictly forward, word by word: with dst>src inside the range, data propagates. Defined behaviour, not an error.
- FILL: one write per cycle; dAddress=dst_ptr, MemWrite=1, dWriteData=fill_value. Busy for len cycles.
- SUM: pipelined reads.
  - SUM_RD issues dAddress=src_ptr each cycle for len cycles.
  - Accumulator adds dReadData in the cycle after each issue.
  - SUM_LAST (1 cycle) absorbs the final word.
  - Busy for len+1 cycles. Sum is modulo 2^32; overflow is discarded.
- DONE: one cycle, done=1, busy=0, then IDLE. A new start is accepted the cycle after DONE.
- Timing: start accepted at edge k → busy high in cycles k+1..k+N (N per op) → done high in cycle k+N+1.
- Counter: remaining-word down-counter of LEN_W bits. The last word is detected at count==1, with no wrap. Address pointers do not wrap; range validity is guaranteed by the start checks.
- MemWrite is never asserted outside CPY_WR and FILL.

Test Plan:
- FILL dst=0x00800100, len=4, fill=0xDEADBEEF → MemWrite high 4 consecutive cycles at 0x100,0x104,0x108,0x10C; done 5 cycles after start; result=4; memory words read back 0xDEADBEEF.
- COPY src=0x00800000 (preloaded 1,2,3), dst=0x00800040, len=3 → writes at 0x40/0x44/0x48 carrying 1,2,3 on alternate cycles; done at cycle 7; result=3.
- SUM src=0x00800000, words 0xFFFFFFFF,0x00000002,0x10 → result=0x00000011 (wrap); busy 4 cycles; done cycle 5.
- Errors, each → done next cycle, error=1, no MemWrite; then a valid command clears error.
  - op=3.
  - dst=0x00800002 (misaligned).
  - dst=0x00801FFC, len=2 (range exits an 8 KB window).
  - src=0x00400000.
- len=0 FILL → done next cycle, result=0, error=0, no write. start while busy during a COPY → ignored, copy completes unchanged.
- rst asserted mid-FILL after 2 of 8 writes → next cycle busy=0, MemWrite=0, no done; only 2 words modified; a new FILL afterwards works normally.
